write_req_arbiter: RTL and testbench

//   Shares one WriteReq.master output among NUM_REQ write requesters with round-robin arbitration.

---
 rtl/write_req_pkg.sv | 22 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/write_req_arbiter.sv | 107 ++++++++++
 tb/tb_write_req_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/write_req_pkg.sv
// write_req_pkg: shared widths, write beat type and a round-robin pick helper
//   ADDR_W/DATA_W : WriteReq address/data widths
//   write_beat_t  : one address+data beat
//   rr_pick       : {found, idx} of first valid bit scanning ptr, ptr+1, ... modulo n
package write_req_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } write_beat_t;
    function automatic logic [4:0] rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input int n);
        logic [4:0] r;
        int k;
        r = '0;
        for (int s = n - 1; s >= 0; s--) begin
            k = (int'(ptr) + s) % n;
            if (valid[k]) r = {1'b1, 4'(k)};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick over N requests
//   valid : request vector
//   ptr   : highest-priority index
//   grant : one-hot of the picked request (zero when none valid)
//   idx   : picked index (ptr when none valid)
//   found : any request valid
module rr_priority_picker #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          found
);
    logic [N-1:0] w_rot;
    logic [PW:0]  w_off;
    logic [PW:0]  w_sum;
    always_comb begin
        // rotating the doubled vector puts ptr at bit 0, so a plain LSB-first encode gives the offset
        w_rot = N'({valid, valid} >> ptr);
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) if (w_rot[i]) w_off = (PW+1)'(i);
        w_sum = {1'b0, ptr} + w_off;
        idx   = (w_sum >= (PW+1)'(N)) ? PW'(w_sum - (PW+1)'(N)) : w_sum[PW-1:0];
        found = |valid;
        grant = found ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/write_req_arbiter.sv
// write_req_arbiter: round-robin arbiter sharing one registered WriteReq output among NUM_REQ sources
//   CLK, RST          : clock, synchronous active-high reset
//   in_valid/address/data : per-requester beat, requester k at slice k
//   in_ready          : one-hot accept of the picked requester
//   req_out_*         : WriteReq.master drive (address, data, valid)
//   out_ready         : consumer accepts req_out this cycle
//   grant_id          : requester index of the beat on req_out
//   Optional: define WRITE_ARB_BURST_LOCK_EN to keep priority on a requester for up to MAX_BURST beats
module write_req_arbiter
    import write_req_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        in_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] in_address,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    output logic [NUM_REQ-1:0]        in_ready,
    output logic [ADDR_W-1:0]         req_out_address,
    output logic [DATA_W-1:0]         req_out_data,
    output logic                      req_out_valid,
    input  logic                      out_ready,
    output logic [GW-1:0]             grant_id
);
    if (NUM_REQ < 1 || NUM_REQ > 16 || MAX_BURST < 1) begin : g_bad_cfg
        $error("write_req_arbiter: illegal NUM_REQ or MAX_BURST");
    end
    logic [NUM_REQ-1:0] w_grant;
    logic [GW-1:0]      w_idx;
    logic [GW-1:0]      w_idx_inc;
    logic [GW-1:0]      w_ptr_nxt;
    logic               w_found;
    logic               w_slot_free;
    logic               w_accept;
    write_beat_t        w_beat_in;
    write_beat_t        r_beat;
    logic               r_valid;
    logic [GW-1:0]      r_gid;
    logic [GW-1:0]      r_ptr;
    rr_priority_picker #(.N(NUM_REQ)) u_pick (
        .valid (in_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx),
        .found (w_found)
    );
    always_comb begin
        w_slot_free       = !r_valid || out_ready;
        w_accept          = !RST && w_slot_free && w_found;
        in_ready          = w_accept ? w_grant : '0;
        w_beat_in.address = in_address[w_idx * ADDR_W +: ADDR_W];
        w_beat_in.data    = in_data[w_idx * DATA_W +: DATA_W];
        w_idx_inc         = (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + GW'(1);
    end
`ifdef WRITE_ARB_BURST_LOCK_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] r_burst;
    logic [BW-1:0] w_burst_nxt;
    logic [BW-1:0] w_cnt_eff;
    logic          w_lock;
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst;
        w_lock      = 1'b0;
        // a grant to someone other than the lock owner starts a fresh burst
        w_cnt_eff   = (w_idx == r_ptr) ? r_burst : '0;
        if (w_accept) begin
            w_lock      = int'(w_cnt_eff) < MAX_BURST - 1;
            w_ptr_nxt   = w_lock ? w_idx : w_idx_inc;
            w_burst_nxt = w_lock ? w_cnt_eff + BW'(1) : '0;
        end else if (r_burst != '0 && !in_valid[r_ptr]) begin
            w_ptr_nxt   = (int'(r_ptr) == NUM_REQ - 1) ? '0 : r_ptr + GW'(1);
            w_burst_nxt = '0;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) r_burst <= '0;
        else     r_burst <= w_burst_nxt;
    end
`else
    assign w_ptr_nxt = w_accept ? w_idx_inc : r_ptr;
`endif
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_beat  <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            if (w_accept) begin
                r_valid <= 1'b1;
                r_beat  <= w_beat_in;
                r_gid   <= w_idx;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end
    assign req_out_address = r_beat.address;
    assign req_out_data    = r_beat.data;
    assign req_out_valid   = r_valid;
    assign grant_id        = r_gid;
endmodule

// File: tb/tb_write_req_arbiter.sv
// tb_write_req_arbiter: directed and randomized checks of write_req_arbiter against a queue-free behavioural model
module tb_write_req_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
`ifdef WRITE_ARB_BURST_LOCK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif
    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  in_valid = '0;
    logic [N*32-1:0] in_address = '0;
    logic [N*8-1:0]  in_data = '0;
    logic [N-1:0]  in_ready;
    logic [31:0]   req_out_address;
    logic [7:0]    req_out_data;
    logic          req_out_valid;
    logic          out_ready = 1'b1;
    logic [1:0]    grant_id;

    write_req_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_address(in_address), .in_data(in_data),
        .in_ready(in_ready), .req_out_address(req_out_address), .req_out_data(req_out_data),
        .req_out_valid(req_out_valid), .out_ready(out_ready), .grant_id(grant_id)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit          src_v[N];
    logic [31:0] src_a[N];
    logic [7:0]  src_d[N];
    bit          refill;
    bit          exp_valid;
    logic [31:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_gid;
    logic [N-1:0] exp_ready;
    logic [N-1:0] got_ready;
    int          m_ptr;
    int          m_streak;

    function automatic int model_pick();
        for (int s = 0; s < N; s++)
            if (src_v[(m_ptr + s) % N]) return (m_ptr + s) % N;
        return -1;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            in_valid[k]          = src_v[k];
            in_address[k*32 +: 32] = src_a[k];
            in_data[k*8 +: 8]    = src_d[k];
        end
    endtask

    task automatic new_beat(input int k);
        src_v[k] = 1'b1;
        src_a[k] = $urandom;
        src_d[k] = 8'($urandom);
    endtask

    // one clock: predict accept from the model, advance DUT and model, then refresh sources
    task automatic tick();
        int k;
        bit owner_valid;
        drive();
        #1;
        k = (RST || (exp_valid && !out_ready)) ? -1 : model_pick();
        exp_ready = (k < 0) ? '0 : (N'(1) << k);
        got_ready = in_ready;
        owner_valid = src_v[m_ptr];
        @(posedge CLK);
        #1;
        if (RST) begin
            exp_valid = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = 0; m_ptr = 0; m_streak = 0;
        end else if (k >= 0) begin
            exp_valid = 1'b1; exp_addr = src_a[k]; exp_data = src_d[k]; exp_gid = k;
            m_streak = (BL && k == m_ptr) ? m_streak + 1 : 1;
            if (BL && m_streak < MB) m_ptr = k;
            else begin m_ptr = (k + 1) % N; m_streak = 0; end
            if (refill) new_beat(k); else src_v[k] = 1'b0;
        end else begin
            if (out_ready) exp_valid = 1'b0;
            if (BL && m_streak > 0 && !owner_valid) begin m_ptr = (m_ptr + 1) % N; m_streak = 0; end
        end
        drive();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) src_v[k] = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; out_ready = 1'b1; refill = 1'b1;
        for (int k = 0; k < N; k++) new_beat(k);
        repeat (2) begin
            tick();
            checks += 2;
            if (got_ready !== '0) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", got_ready); end
            if (req_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", req_out_valid); end
        end
        checks++;
        if (req_out_address !== 32'h0 || req_out_data !== 8'h0 || grant_id !== 2'd0) begin
            errors++; $display("FAIL reset_regs: got %h/%h/%0d want 0/0/0", req_out_address, req_out_data, grant_id);
        end
        RST = 1'b0;
        tick();
        checks += 3;
        if (got_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b want 0001", got_ready); end
        if (grant_id !== 2'd0 || req_out_valid !== 1'b1) begin
            errors++; $display("FAIL reset_first_out: got id %0d v %b want id 0 v 1", grant_id, req_out_valid);
        end
        if (req_out_address !== exp_addr) begin errors++; $display("FAIL reset_first_addr: got %h want %h", req_out_address, exp_addr); end
    endtask

    task automatic test_round_robin();
        int want;
        do_reset();
        refill = 1'b1;
        for (int k = 0; k < N; k++) new_beat(k);
        for (int i = 0; i < 5; i++) begin
            want = BL ? ((i < 4) ? 0 : 1) : (i % N);
            tick();
            checks += 3;
            if (got_ready !== (N'(1) << want)) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, got_ready, N'(1) << want); end
            if (grant_id !== 2'(want) || req_out_valid !== 1'b1) begin
                errors++; $display("FAIL rr_grant[%0d]: got id %0d v %b want id %0d v 1", i, grant_id, req_out_valid, want);
            end
            if (req_out_address !== exp_addr || req_out_data !== exp_data) begin
                errors++; $display("FAIL rr_beat[%0d]: got %h/%h want %h/%h", i, req_out_address, req_out_data, exp_addr, exp_data);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        refill = 1'b0;
        src_v[2] = 1'b1; src_a[2] = 32'h1000_0040; src_d[2] = 8'hA5;
        tick();
        checks += 2;
        if (got_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", got_ready); end
        if (req_out_address !== 32'h1000_0040 || req_out_data !== 8'hA5 || req_out_valid !== 1'b1 || grant_id !== 2'd2) begin
            errors++; $display("FAIL single_out: got %h/%h/%b/%0d want 10000040/a5/1/2", req_out_address, req_out_data, req_out_valid, grant_id);
        end
        for (int k = 0; k < N; k++) new_beat(k);
        tick();
        checks++;
        if (got_ready !== (BL ? 4'b0100 : 4'b1000)) begin
            errors++; $display("FAIL single_next_ptr: got %b want %b", got_ready, BL ? 4'b0100 : 4'b1000);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ha;
        logic [7:0]  hd;
        do_reset();
        refill = 1'b0;
        new_beat(0);
        ha = src_a[0]; hd = src_d[0];
        tick();
        out_ready = 1'b0;
        new_beat(1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks += 2;
            if (got_ready !== '0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, got_ready); end
            if (req_out_valid !== 1'b1 || req_out_address !== ha || req_out_data !== hd || grant_id !== 2'd0) begin
                errors++; $display("FAIL bp_hold[%0d]: got %b/%h/%h/%0d want 1/%h/%h/0", i, req_out_valid, req_out_address, req_out_data, grant_id, ha, hd);
            end
        end
        out_ready = 1'b1;
        ha = src_a[1];
        tick();
        checks += 2;
        if (got_ready !== 4'b0010) begin errors++; $display("FAIL bp_fill_ready: got %b want 0010", got_ready); end
        if (req_out_valid !== 1'b1 || req_out_address !== ha || grant_id !== 2'd1) begin
            errors++; $display("FAIL bp_no_bubble: got %b/%h/%0d want 1/%h/1", req_out_valid, req_out_address, grant_id, ha);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        refill = 1'b0;
        new_beat(2);
        tick();
        new_beat(0);
        tick();
        checks += 2;
        if (got_ready !== 4'b0001) begin errors++; $display("FAIL wrap_ready: got %b want 0001", got_ready); end
        if (grant_id !== 2'd0 || req_out_valid !== 1'b1) begin errors++; $display("FAIL wrap_grant: got %0d want 0", grant_id); end
        for (int k = 0; k < N; k++) new_beat(k);
        tick();
        checks++;
        if (got_ready !== (BL ? 4'b0001 : 4'b0010)) begin
            errors++; $display("FAIL wrap_next_ptr: got %b want %b", got_ready, BL ? 4'b0001 : 4'b0010);
        end
    endtask

    task automatic test_burst();
        int want;
        do_reset();
        refill = 1'b1;
        new_beat(0);
        new_beat(1);
        for (int i = 0; i < 9; i++) begin
            want = BL ? ((i < 4) ? 0 : (i < 8) ? 1 : 0) : (i % 2);
            tick();
            checks++;
            if (grant_id !== 2'(want)) begin errors++; $display("FAIL burst_seq[%0d]: got %0d want %0d", i, grant_id, want); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom % 4) != 0;
            RST = ($urandom % 60) == 0;
            refill = 1'($urandom % 2);
            for (int k = 0; k < N; k++) if (!src_v[k] && ($urandom % 3) == 0) new_beat(k);
            tick();
            checks += 3;
            if (got_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, got_ready, exp_ready); end
            if (req_out_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, req_out_valid, exp_valid); end
            if (req_out_address !== exp_addr || req_out_data !== exp_data || grant_id !== 2'(exp_gid)) begin
                errors++; $display("FAIL rand_beat[%0d]: got %h/%h/%0d want %h/%h/%0d", i, req_out_address, req_out_data, grant_id, exp_addr, exp_data, exp_gid);
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_wrap();
        test_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
